mix_sched: RTL

Voice mixing scheduler for the Audrey audio controller. On each one-cycle `sample_req` from the I2S transmitter, it walks the voice slots in order and fetches each voice's sample and left/right volume through a request/acknowledge handshake. One shared multiplier accumulates every voice into left and right sums. The saturated results are held on `left_out`/`right_out`, which the transmitter latches at its next `sample_req`.

---
 rtl/audrey_pkg.sv | 27 ++
 rtl/mix_mac.sv | 48 ++++
 rtl/mix_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/audrey_pkg.sv
// Shared definitions for the Audrey audio controller mixers.
package audrey_pkg;

   localparam int SAMPLE_W = 16;
   localparam int VOL_W    = 8;
   localparam int PROD_W   = SAMPLE_W + VOL_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      MUL_L,
      MUL_R,
      DONE
   } mix_state_t;

   // Clamp a wide signed value into the signed 16-bit sample range.
   function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [63:0] value);
      if (value > 64'sd32767) begin
         sat16 = 16'h7FFF;
      end else if (value < -64'sd32768) begin
         sat16 = 16'h8000;
      end else begin
         sat16 = value[SAMPLE_W-1:0];
      end
   endfunction

endpackage

// File: rtl/mix_mac.sv
// Time-shared signed 16x9 multiply-accumulate feeding separate left/right accumulators.
module mix_mac
   import audrey_pkg::*;
#(
   parameter int ACC_W = 27
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_clear,
   input  logic                    i_add,
   input  logic                    i_sel,
   input  logic [SAMPLE_W-1:0]     i_sample,
   input  logic [VOL_W-1:0]        i_vol,
   output logic signed [ACC_W-1:0] o_accL,
   output logic signed [ACC_W-1:0] o_accR
);

   logic signed [PROD_W-1:0] w_sampleExt;
   logic signed [PROD_W-1:0] w_volExt;
   logic signed [PROD_W-1:0] w_prod;
   logic signed [ACC_W-1:0]  w_prodExt;

   // The volume is an unsigned gain, so it is zero-extended before the signed multiply.
   always_comb begin
      w_sampleExt = {{(PROD_W-SAMPLE_W){i_sample[SAMPLE_W-1]}}, i_sample};
      w_volExt    = {{(PROD_W-VOL_W){1'b0}}, i_vol};
      w_prod      = w_sampleExt * w_volExt;
      w_prodExt   = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
   end

   // One multiplier, with i_sel steering the product into the left or right accumulator.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_accL <= '0;
         o_accR <= '0;
      end else if (i_clear) begin
         o_accL <= '0;
         o_accR <= '0;
      end else if (i_add) begin
         if (i_sel) begin
            o_accR <= o_accR + w_prodExt;
         end else begin
            o_accL <= o_accL + w_prodExt;
         end
      end
   end

endmodule

// File: rtl/mix_sched.sv
// Voice mixing scheduler: fetches each voice per frame and mixes it into saturated L/R outputs.
module mix_sched
   import audrey_pkg::*;
#(
   parameter  int NUM_VOICES = 4,
   localparam int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
   localparam int ACC_W      = PROD_W + $clog2(NUM_VOICES) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_req,
   output logic                voice_req,
   output logic [IDX_W-1:0]    voice_idx,
   input  logic                voice_ack,
   input  logic [SAMPLE_W-1:0] voice_sample,
   input  logic [VOL_W-1:0]    voice_vol_l,
   input  logic [VOL_W-1:0]    voice_vol_r,
   output logic [SAMPLE_W-1:0] left_out,
   output logic [SAMPLE_W-1:0] right_out,
   output logic                busy,
   output logic                overrun
);

   mix_state_t r_state;
   mix_state_t w_nextState;

   logic [IDX_W-1:0]    r_idx;
   logic [SAMPLE_W-1:0] r_sample;
   logic [VOL_W-1:0]    r_volL;
   logic [VOL_W-1:0]    r_volR;
   logic [SAMPLE_W-1:0] r_leftOut;
   logic [SAMPLE_W-1:0] r_rightOut;
   logic                r_overrun;

   logic                w_lastVoice;
   logic                w_clear;
   logic                w_add;
   logic                w_sel;
   logic [VOL_W-1:0]    w_vol;

   logic signed [ACC_W-1:0] w_accL;
   logic signed [ACC_W-1:0] w_accR;
   logic signed [63:0]      w_accLExt;
   logic signed [63:0]      w_accRExt;

   assign w_lastVoice = (r_idx == IDX_W'(NUM_VOICES - 1));

   // State register; reset aborts any frame in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic plus the MAC control strobes derived from the current state.
   always_comb begin
      w_nextState = r_state;
      w_clear     = 1'b0;
      w_add       = 1'b0;
      w_sel       = 1'b0;
      w_vol       = r_volL;
      case (r_state)
         IDLE: begin
            if (sample_req) begin
               w_clear     = 1'b1;
               w_nextState = FETCH;
            end
         end
         FETCH: begin
            if (voice_ack) begin
               w_nextState = MUL_L;
            end
         end
         MUL_L: begin
            w_add       = 1'b1;
            w_nextState = MUL_R;
         end
         MUL_R: begin
            w_add       = 1'b1;
            w_sel       = 1'b1;
            w_vol       = r_volR;
            w_nextState = w_lastVoice ? DONE : FETCH;
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Voice index, captured voice data, final outputs and the overrun pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx      <= '0;
         r_sample   <= '0;
         r_volL     <= '0;
         r_volR     <= '0;
         r_leftOut  <= '0;
         r_rightOut <= '0;
         r_overrun  <= 1'b0;
      end else begin
         r_overrun <= sample_req && (r_state != IDLE);
         if ((r_state == IDLE) && sample_req) begin
            r_idx <= '0;
         end else if ((r_state == MUL_R) && !w_lastVoice) begin
            r_idx <= r_idx + 1'b1;
         end
         if ((r_state == FETCH) && voice_ack) begin
            r_sample <= voice_sample;
            r_volL   <= voice_vol_l;
            r_volR   <= voice_vol_r;
         end
         if (r_state == DONE) begin
            r_leftOut  <= sat16(w_accLExt >>> 8);
            r_rightOut <= sat16(w_accRExt >>> 8);
         end
      end
   end

   // Accumulators are sign-extended to a fixed width so the shared sat16 helper can be used.
   always_comb begin
      w_accLExt = {{(64-ACC_W){w_accL[ACC_W-1]}}, w_accL};
      w_accRExt = {{(64-ACC_W){w_accR[ACC_W-1]}}, w_accR};
   end

   mix_mac #(
      .ACC_W (ACC_W)
   ) u_mac (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .i_clear  (w_clear),
      .i_add    (w_add),
      .i_sel    (w_sel),
      .i_sample (r_sample),
      .i_vol    (w_vol),
      .o_accL   (w_accL),
      .o_accR   (w_accR)
   );

   assign voice_req = (r_state == FETCH);
   assign voice_idx = r_idx;
   assign busy      = (r_state != IDLE);
   assign overrun   = r_overrun;
   assign left_out  = r_leftOut;
   assign right_out = r_rightOut;

endmodule
